// File: rtl/lcd_sequencer_if.sv
// User-request pulses into the LCD sequencer and the registered timebase
// it presents to the LCD output-action stage.
interface lcd_sequencer_if;
    logic        setup_req;
    logic        sel_time;
    logic        sel_tz;
    logic        exit;
    logic [3:0]  state;
    logic [31:0] cnt;
    logic [3:0]  char_cnt;
    logic        lcd_e;
    logic        in_setup;

    // Request source (user interface / testbench) side.
    modport master (
        output setup_req, sel_time, sel_tz, exit,
        input  state, cnt, char_cnt, lcd_e, in_setup
    );

    // Sequencer side.
    modport slave (
        input  setup_req, sel_time, sel_tz, exit,
        output state, cnt, char_cnt, lcd_e, in_setup
    );
endinterface

// File: rtl/lcd_sequencer.sv
// Master sequencer for the character-LCD write path: power-on init, then a
// continuous LINE1/LINE2 refresh loop, with entry to and exit from the setup
// menu only at frame boundaries. All outputs come straight from registers.
module lcd_sequencer #(
    parameter int unsigned INIT_DELAY = 70,
    parameter int unsigned CMD_HOLD   = 30,
    parameter int unsigned CLEAR_HOLD = 20,
    parameter int unsigned LINE1_LEN  = 20,
    parameter int unsigned LINE2_LEN  = 20,
    parameter int unsigned MENU_CHARS = 8
) (
    input  logic           clk,
    input  logic           resetn,
    lcd_sequencer_if.slave bus
);

    typedef enum logic [3:0] {
        S_INIT   = 4'b0000,
        S_FUNC   = 4'b0001,
        S_ISETUP = 4'b0010,
        S_CLEAR  = 4'b0011,
        S_SETUP  = 4'b0100,
        S_TIME   = 4'b0101,
        S_TZ     = 4'b0110,
        S_LINE1  = 4'b1000,
        S_LINE2  = 4'b1001
    } state_t;

    // Final-cycle CNT values for the fixed-length states.
    localparam logic [31:0] INIT_LAST  = 32'(INIT_DELAY - 1);
    localparam logic [31:0] CMD_LAST   = 32'(CMD_HOLD - 1);
    localparam logic [31:0] CLEAR_LAST = 32'(CLEAR_HOLD - 1);
    localparam logic [31:0] LINE1_LAST = 32'(LINE1_LEN - 1);
    localparam logic [31:0] LINE2_LAST = 32'(LINE2_LEN - 1);
    localparam logic [3:0]  MENU_LAST  = 4'(MENU_CHARS - 1);

    state_t      state_q, state_d;
    state_t      ret_q, ret_d;      // where CLEAR_SCREEN goes when it finishes
    logic [31:0] cnt_q, cnt_d;
    logic [3:0]  char_q, char_d;
    logic        pend_q, pend_d;    // setup request waiting for the frame end
    logic        lcd_e_q, lcd_e_d;
    logic        in_setup_q, in_setup_d;

    // Next-state, return-target, pending-request and output-register values.
    always_comb begin
        // NOTE: every signal written here is given a default first, so no path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        ret_d   = ret_q;
        pend_d  = pend_q;

        case (state_q)
            S_INIT:   if (cnt_q == INIT_LAST)  state_d = S_FUNC;
            S_FUNC:   if (cnt_q == CMD_LAST)   state_d = S_ISETUP;
            S_ISETUP: if (cnt_q == CMD_LAST)   state_d = S_CLEAR;
            S_CLEAR:  if (cnt_q == CLEAR_LAST) state_d = ret_q;
            S_LINE1: begin
                if (bus.setup_req) pend_d = 1'b1;
                if (cnt_q == LINE1_LAST) state_d = S_LINE2;
            end
            S_LINE2: begin
                if (cnt_q == LINE2_LAST) begin
                    // A request arriving in the frame's last cycle still counts.
                    if (pend_q || bus.setup_req) begin
                        state_d = S_CLEAR;
                        ret_d   = S_SETUP;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = S_LINE1;
                    end
                end else if (bus.setup_req) begin
                    pend_d = 1'b1;
                end
            end
            S_SETUP: begin
                if (bus.exit) begin
                    state_d = S_CLEAR;
                    ret_d   = S_LINE1;
                end else if (char_q == MENU_LAST) begin
                    // Selections only accepted once the whole menu is drawn.
                    if (bus.sel_time)    state_d = S_TIME;
                    else if (bus.sel_tz) state_d = S_TZ;
                end
            end
            S_TIME, S_TZ: begin
                if (bus.exit) begin
                    state_d = S_CLEAR;
                    ret_d   = S_SETUP;
                end
            end
            default: state_d = S_INIT;
        endcase

        cnt_d = (state_d != state_q) ? '0 : cnt_q + 32'd1;

        char_d = '0;
        if (state_d == S_SETUP && state_q == S_SETUP)
            char_d = (char_q == MENU_LAST) ? char_q : char_q + 4'd1;

        lcd_e_d    = (state_d != S_INIT);
        in_setup_d = (state_d == S_SETUP) || (state_d == S_TIME) || (state_d == S_TZ);
    end

    // Sequencer registers; reset restarts the full init sequence.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_INIT;
            ret_q      <= S_LINE1;
            cnt_q      <= '0;
            char_q     <= '0;
            pend_q     <= 1'b0;
            lcd_e_q    <= 1'b0;
            in_setup_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples the pre-edge values computed above.
            state_q    <= state_d;
            ret_q      <= ret_d;
            cnt_q      <= cnt_d;
            char_q     <= char_d;
            pend_q     <= pend_d;
            lcd_e_q    <= lcd_e_d;
            in_setup_q <= in_setup_d;
        end
    end

    assign bus.state    = state_q;
    assign bus.cnt      = cnt_q;
    assign bus.char_cnt = char_q;
    assign bus.lcd_e    = lcd_e_q;
    assign bus.in_setup = in_setup_q;

endmodule
